// File: rtl/alarm_clock_pkg.sv
// Shared types, digit limits and legality check for the alarm-clock time registers.
package alarm_clock_pkg;

   typedef logic [3:0] digit_t;

   localparam digit_t MAX_MS_HR      = 4'd2;
   localparam digit_t MAX_LS_HR_AT_2 = 4'd3;
   localparam digit_t MAX_MS_MIN     = 4'd5;
   localparam digit_t MAX_BCD        = 4'd9;

   // Four-digit BCD time, most significant digit first.
   typedef struct packed {
      digit_t ms_hr;
      digit_t ls_hr;
      digit_t ms_min;
      digit_t ls_min;
   } bcd_time_t;

   // True when the four digits form a legal 24-hour HH:MM time.
   function automatic logic bcd_time_legal(input digit_t ms_hr,
                                           input digit_t ls_hr,
                                           input digit_t ms_min,
                                           input digit_t ls_min);
      logic hr_ok;
      begin
         hr_ok = ((ms_hr < MAX_MS_HR) && (ls_hr <= MAX_BCD)) ||
                 ((ms_hr == MAX_MS_HR) && (ls_hr <= MAX_LS_HR_AT_2));
         return hr_ok && (ms_min <= MAX_MS_MIN) && (ls_min <= MAX_BCD);
      end
   endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit: synchronous clear to its reset value, parallel load, and
// increment that wraps to 0 at MAX (or early when force_wrap is set).
module bcd_digit_counter
   import alarm_clock_pkg::*;
#(
   parameter digit_t MAX       = MAX_BCD,
   parameter digit_t RESET_VAL = 4'd0
) (
   input  logic   clock,
   input  logic   clear,
   input  logic   load,
   input  digit_t load_val,
   input  logic   inc,
   input  logic   force_wrap,
   output digit_t value,
   output logic   carry_c
);

   digit_t value_d, value_q;
   logic   at_limit_c;

   // Next digit value and carry-out; clear beats load beats increment.
   always_comb begin
      value_d    = value_q;
      carry_c    = 1'b0;
      at_limit_c = (value_q >= MAX) || force_wrap;
      if (clear) begin
         value_d = RESET_VAL;
      end else if (load) begin
         value_d = load_val;
      end else if (inc) begin
         if (at_limit_c) begin
            value_d = 4'd0;
            carry_c = 1'b1;
         end else begin
            value_d = digit_t'(value_q + 4'd1);
         end
      end
   end

   // Digit register.
   always_ff @(posedge clock) begin
      value_q <= value_d;
   end

   assign value = value_q;

endmodule

// File: rtl/time_counter.sv
// Current-time register: 24-hour BCD HH:MM advanced by one_minute, loadable
// from the controller, with load/wrap status pulses and a blinking colon.
module time_counter
   import alarm_clock_pkg::*;
#(
   parameter logic        COLON_INIT  = 1'b1,
   parameter logic [15:0] RESET_HH_MM = 16'h0000
) (
   input  logic   clock,
   input  logic   reset,
   input  logic   one_minute,
   input  logic   one_second,
   input  logic   load_new_c,
   input  digit_t new_current_time_ms_hr,
   input  digit_t new_current_time_ls_hr,
   input  digit_t new_current_time_ms_min,
   input  digit_t new_current_time_ls_min,
   output digit_t current_time_ms_hr,
   output digit_t current_time_ls_hr,
   output digit_t current_time_ms_min,
   output digit_t current_time_ls_min,
   output logic   load_ack,
   output logic   load_err,
   output logic   day_wrap,
   output logic   colon
);

   bcd_time_t new_time_c;
   bcd_time_t cur_time_c;
   logic      load_legal_c;
   logic      digit_load_c;
   logic      advance_c;
   logic      hour_wrap_c;
   logic      ls_min_carry_c, ms_min_carry_c, ls_hr_carry_c, ms_hr_carry_c;

   logic load_ack_d, load_ack_q;
   logic load_err_d, load_err_q;
   logic day_wrap_d, day_wrap_q;
   logic colon_d,    colon_q;

   // Load qualification and minute advance; a load always swallows one_minute.
   always_comb begin
      new_time_c   = '{ms_hr:  new_current_time_ms_hr,
                       ls_hr:  new_current_time_ls_hr,
                       ms_min: new_current_time_ms_min,
                       ls_min: new_current_time_ls_min};
      load_legal_c = bcd_time_legal(new_time_c.ms_hr, new_time_c.ls_hr,
                                    new_time_c.ms_min, new_time_c.ls_min);
      digit_load_c = load_new_c && load_legal_c && !reset;
      advance_c    = one_minute && !load_new_c && !reset;
      hour_wrap_c  = (cur_time_c.ms_hr == MAX_MS_HR) &&
                     (cur_time_c.ls_hr == MAX_LS_HR_AT_2);
   end

   bcd_digit_counter #(
      .MAX       (MAX_BCD),
      .RESET_VAL (digit_t'(RESET_HH_MM[3:0]))
   ) u_ls_min (
      .clock      (clock),
      .clear      (reset),
      .load       (digit_load_c),
      .load_val   (new_time_c.ls_min),
      .inc        (advance_c),
      .force_wrap (1'b0),
      .value      (cur_time_c.ls_min),
      .carry_c    (ls_min_carry_c)
   );

   bcd_digit_counter #(
      .MAX       (MAX_MS_MIN),
      .RESET_VAL (digit_t'(RESET_HH_MM[7:4]))
   ) u_ms_min (
      .clock      (clock),
      .clear      (reset),
      .load       (digit_load_c),
      .load_val   (new_time_c.ms_min),
      .inc        (ls_min_carry_c),
      .force_wrap (1'b0),
      .value      (cur_time_c.ms_min),
      .carry_c    (ms_min_carry_c)
   );

   // Hour units wrap at 9 normally, but at 3 when the tens digit is 2.
   bcd_digit_counter #(
      .MAX       (MAX_BCD),
      .RESET_VAL (digit_t'(RESET_HH_MM[11:8]))
   ) u_ls_hr (
      .clock      (clock),
      .clear      (reset),
      .load       (digit_load_c),
      .load_val   (new_time_c.ls_hr),
      .inc        (ms_min_carry_c),
      .force_wrap (hour_wrap_c),
      .value      (cur_time_c.ls_hr),
      .carry_c    (ls_hr_carry_c)
   );

   // Hour tens only carries out on the 23:59 -> 00:00 advance.
   bcd_digit_counter #(
      .MAX       (MAX_MS_HR),
      .RESET_VAL (digit_t'(RESET_HH_MM[15:12]))
   ) u_ms_hr (
      .clock      (clock),
      .clear      (reset),
      .load       (digit_load_c),
      .load_val   (new_time_c.ms_hr),
      .inc        (ls_hr_carry_c),
      .force_wrap (1'b0),
      .value      (cur_time_c.ms_hr),
      .carry_c    (ms_hr_carry_c)
   );

   // Status pulses and colon toggle for the next cycle.
   always_comb begin
      load_ack_d = 1'b0;
      load_err_d = 1'b0;
      day_wrap_d = 1'b0;
      colon_d    = colon_q;
      if (one_second) begin
         colon_d = ~colon_q;
      end
      if (load_new_c) begin
         load_ack_d = load_legal_c;
         load_err_d = !load_legal_c;
      end
      day_wrap_d = ms_hr_carry_c;
   end

   // Status and colon registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         load_ack_q <= 1'b0;
         load_err_q <= 1'b0;
         day_wrap_q <= 1'b0;
         colon_q    <= COLON_INIT;
      end else begin
         load_ack_q <= load_ack_d;
         load_err_q <= load_err_d;
         day_wrap_q <= day_wrap_d;
         colon_q    <= colon_d;
      end
   end

   assign current_time_ms_hr  = cur_time_c.ms_hr;
   assign current_time_ls_hr  = cur_time_c.ls_hr;
   assign current_time_ms_min = cur_time_c.ms_min;
   assign current_time_ls_min = cur_time_c.ls_min;
   assign load_ack            = load_ack_q;
   assign load_err            = load_err_q;
   assign day_wrap            = day_wrap_q;
   assign colon               = colon_q;

endmodule

// File: doc/time_counter.md
# time_counter

Current-time register of the alarm clock. It consumes the one_minute and one_second pulses from the time-generation unit and keeps a 24-hour BCD time (HH:MM). It accepts a new time from the alarm controller's load command and drives the four current-time digits to the display driver and the alarm comparator.

## Interface
- COLON_INIT, 1'b1: reset value of colon.
- RESET_HH_MM, 16'h0000: reset time as four packed BCD digits {ms_hour, ls_hour, ms_minute, ls_minute}; must be a legal time.
- clock  input  1  system clock (256 Hz nominal); all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- one_minute  input  1  single-cycle advance pulse (becomes one_second rate in fastwatch, upstream).
- one_second  input  1  single-cycle pulse; toggles colon.
- load_new_c  input  1  single-cycle request to load new_current_time.
- new_current_time_ms_hr  input  4  BCD, legal 0-2.
- new_current_time_ls_hr  input  4  BCD, legal 0-9, or 0-3 when ms_hr is 2.
- new_current_time_ms_min  input  4  BCD, legal 0-5.
- new_current_time_ls_min  input  4  BCD, legal 0-9.
- current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min  output  4 each  registered BCD time.
- load_ack  output  1  one-cycle pulse: load accepted.
- load_err  output  1  one-cycle pulse: load rejected (illegal digits).
- day_wrap  output  1  one-cycle pulse on the 23:59 -> 00:00 advance.
- colon  output  1  display colon, blinks at 0.5 Hz.

## Operation
- Priority each cycle: reset > load_new_c > one_minute. one_second acts independently on colon.
- Load: all four digits are checked together.
  - Legal: time register takes the new digits and load_ack pulses.
  - Illegal (any digit out of range, including hour 24-29 or any nibble above 9): time unchanged and load_err pulses.
  - A one_minute in the same cycle is dropped in both cases.
- Advance on one_minute, with no load pending:
  - ls_min 9 -> 0 carries into ms_min.
  - ms_min 5 -> 0 carries into the hour.
  - Hour 09 -> 10, 19 -> 20, 23 -> 00.
  - A 23:59 advance gives 00:00 and a day_wrap pulse.
- The counter is pure BCD. No binary intermediate and no digit ever leaves its legal range.
- colon: inverted on every one_second pulse. Unaffected by load.
- Reset outputs:
  - time = RESET_HH_MM
  - colon = COLON_INIT
  - load_ack = load_err = day_wrap = 0
- Reset mid-operation discards any load or pulse sampled in the same cycle.

## Timing
- All outputs are registered. The response to any input sampled at edge N is visible after edge N.
- Load latency 1 cycle: load_new_c high at edge N gives the new digits and load_ack after edge N.
- Advance latency 1 cycle, including full carry ripple (e.g. 19:59 -> 20:00 in one cycle).
- day_wrap is high for exactly the cycle in which the outputs first read 00:00 after the wrap.
- Back-to-back one_minute pulses on consecutive cycles each advance the time by one minute. Nothing is lost.
- load_ack and load_err are mutually exclusive and never high for two consecutive cycles unless load_new_c is.
- The controller treats load_ack as its cue to assert reset_count to the time generator. This block does not drive reset_count.

## Structure
- Shared package alarm_clock_pkg holds:
  - typedef digit_t (logic [3:0])
  - constants MAX_MS_HR=2, MAX_LS_HR_AT_2=3, MAX_MS_MIN=5, MAX_BCD=9
  - function bcd_time_legal(ms_hr, ls_hr, ms_min, ls_min), reused by the alarm-time register
- Sub-module bcd_digit_counter: one BCD digit with parameter MAX, inputs clear/load/inc, output carry. Four instances.
  - The ls_hr instance's wrap limit is overridden at 23 by the top-level hour-wrap logic.

## Test plan
- Reset with default parameters -> 00:00, colon=1, all pulses 0. Repeat with RESET_HH_MM=16'h1234 -> outputs 12:34.
- Load 23:58, then two one_minute pulses -> 23:59, then 00:00 with day_wrap high for exactly that one cycle.
- Load 09:59, one_minute -> 10:00; load 19:59, one_minute -> 20:00, each in one cycle.
- Load 24:00, then 1A:00, then 12:60 -> each gives load_err pulse, time unchanged, load_ack 0.
- load_new_c (legal 07:30) and one_minute in the same cycle -> 07:30, load_ack=1, no advance. Reset together with load -> RESET_HH_MM, no ack.
- 5 one_second pulses from reset -> colon sequence 0,1,0,1,0. 60 consecutive one_minute pulses from 00:00 (fastwatch-rate stimulus) -> 01:00.
